bus_ram: RTL and testbench
==========================

BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of storage words.
REQ-002 SHALL have parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 8: word width.
REQ-004 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port mem_clk, input, 1: CPU memory strobe, synchronous to clk; each rising edge is one access request.
REQ-007 SHALL have port addr, input, ADDR_W: CPU address bus.
REQ-008 SHALL have port wr_en, input, 1: access direction; 1 = write, 0 = read.
REQ-009 SHALL have port data_in, input, DATA_W: shared data bus, as seen by the RAM.
REQ-010 SHALL have port data_out, output, DATA_W: read data for the shared-bus tristate driver.
REQ-011 SHALL have port data_oe, output, 1: tristate enable for data_out onto the shared bus.
REQ-012 SHALL have port load_start, input, 1: begin a program-load session.
REQ-013 SHALL have port load_valid, input, 1: a load beat is present.
REQ-014 SHALL have port load_data, input, DATA_W: load beat payload.
REQ-015 SHALL have port load_last, input, 1: marks the final load beat.
REQ-016 SHALL have port load_ready, output, 1: RAM accepts load beats.
REQ-017 SHALL have port load_done, output, 1: one-cycle pulse at the end of a session.
REQ-018 SHALL have port busy, output, 1: high while a load session is active.

Function
REQ-019 SHALL register mem_clk as mem_clk_q; strobe = mem_clk & ~mem_clk_q.
REQ-020 SHALL implement an FSM with states IDLE, RESPOND and LOAD.
REQ-021 IDLE: on strobe with wr_en=1, SHALL write data_in to mem[addr] at that edge; state stays IDLE; data_oe stays 0.
REQ-022 IDLE: on strobe with wr_en=0, SHALL register data_out = mem[addr] and assert data_oe from the next cycle; go to RESPOND.
REQ-023 RESPOND: data_oe SHALL stay high for exactly 2 cycles, then return to 0 with state IDLE; data_out SHALL hold its value while data_oe is high.
REQ-024 A strobe during RESPOND SHALL be accepted as in IDLE: a read restarts the 2-cycle window with the new data; a write is performed and data_oe is 0 on the next cycle.
REQ-025 data_oe SHALL never be high in LOAD, or in the cycle after a write strobe.
REQ-026 IDLE or RESPOND: load_start SHALL enter LOAD, clear load pointer ptr to 0, drop data_oe, and set busy=1 and load_ready=1 from the next cycle.
REQ-027 If load_start and a strobe coincide, load_start SHALL win and the strobe SHALL be dropped.
REQ-028 LOAD: each cycle with load_valid & load_ready SHALL write load_data to mem[ptr] and increment ptr modulo DEPTH.
REQ-029 LOAD SHALL end on an accepted beat with load_last=1, or on an accepted beat at ptr = DEPTH-1 (wrap).
REQ-030 On LOAD end, the next cycle SHALL have state IDLE, busy=0, load_ready=0, load_done=1 for one cycle and ptr=0.
REQ-031 Strobes and load_start SHALL be ignored during LOAD; load beats SHALL be ignored outside LOAD.
REQ-032 Read data SHALL reflect all writes (CPU or load) completed at earlier edges; same-edge read and write of one address cannot occur.

Reset
REQ-033 On reset: state=IDLE, data_out=0, data_oe=0, busy=0, load_ready=0, load_done=0, ptr=0, mem_clk_q=0.
REQ-034 Memory contents SHALL NOT be cleared by reset; reset mid-LOAD SHALL abort with no load_done, keeping beats already written.
REQ-035 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-036 Load 3 beats 0xA1, 0xB2, 0xC3 with last on the third -> mem[0..2] written; load_done pulses once; busy falls the next cycle.
REQ-037 Write strobe addr=0x10, data 0x5A, then read strobe addr=0x10 -> data_out=0x5A and data_oe high for exactly 2 cycles.
REQ-038 Read strobe in the second RESPOND cycle to a different address -> data_oe stays high continuously; new data appears; window restarts.
REQ-039 Load DEPTH beats with load_last=0 -> session ends on wrap; mem[DEPTH-1] written; load_done=1; ptr=0.
REQ-040 Assert reset after 2 load beats -> IDLE, busy=0, no load_done; a subsequent read of addr 1 returns beat 2.
REQ-041 Strobe with mem_clk held high for 3 cycles -> exactly one access performed.

Source files
------------

// File: rtl/bus_ram.sv
// bus_ram: single-port program/data RAM shared between a CPU memory strobe
// and a streaming program-load port.
//
// Ports
//   clk, reset          : system clock, synchronous active-high reset
//   mem_clk             : CPU memory strobe (rising edge = one access)
//   addr, wr_en, data_in: CPU access address, direction (1 = write), write data
//   data_out, data_oe   : read data and its tristate enable (2-cycle window)
//   load_start          : open a program-load session (pointer restarts at 0)
//   load_valid/data/last: load beat handshake, payload and end-of-session marker
//   load_ready, busy    : high while a load session is active
//   load_done           : one-cycle pulse when a session completes normally
module bus_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESPOND = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_clk_q;
    logic              strobe;
    logic              data_oe_q, data_oe_d;
    // Set during the second cycle of the read window; the window closes after it.
    logic              resp_last_q, resp_last_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              load_done_q, load_done_d;
    logic [DATA_W-1:0] data_out_q;

    // Single write port shared by CPU writes and load beats; one read port.
    logic              rd_en;
    logic              we;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;

    logic [DATA_W-1:0] mem [DEPTH];

    assign strobe = mem_clk & ~mem_clk_q;

    always_comb begin
        state_d     = state_q;
        data_oe_d   = data_oe_q;
        resp_last_d = resp_last_q;
        ptr_d       = ptr_q;
        load_done_d = 1'b0;
        rd_en       = 1'b0;
        we          = 1'b0;
        we_addr     = addr;
        we_data     = data_in;

        case (state_q)
            IDLE, RESPOND: begin
                // Age the read window first; a new access below overrides it.
                if (state_q == RESPOND) begin
                    if (resp_last_q) begin
                        state_d     = IDLE;
                        data_oe_d   = 1'b0;
                        resp_last_d = 1'b0;
                    end else begin
                        resp_last_d = 1'b1;
                    end
                end

                // load_start outranks a coincident strobe, which is dropped.
                if (load_start) begin
                    state_d     = LOAD;
                    ptr_d       = '0;
                    data_oe_d   = 1'b0;
                    resp_last_d = 1'b0;
                end else if (strobe) begin
                    if (wr_en) begin
                        we          = 1'b1;
                        state_d     = IDLE;
                        data_oe_d   = 1'b0;
                        resp_last_d = 1'b0;
                    end else begin
                        rd_en       = 1'b1;
                        state_d     = RESPOND;
                        data_oe_d   = 1'b1;
                        resp_last_d = 1'b0;
                    end
                end
            end

            LOAD: begin
                // load_ready is constantly high here, so valid alone accepts a beat.
                if (load_valid) begin
                    we      = 1'b1;
                    we_addr = ptr_q;
                    we_data = load_data;
                    ptr_d   = ptr_q + 1'b1;
                    if (load_last || (ptr_q == ADDR_W'(DEPTH - 1))) begin
                        state_d     = IDLE;
                        ptr_d       = '0;
                        load_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_clk_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            resp_last_q <= 1'b0;
            ptr_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_clk_q   <= mem_clk;
            data_oe_q   <= data_oe_d;
            resp_last_q <= resp_last_d;
            ptr_q       <= ptr_d;
            load_done_q <= load_done_d;
        end
    end

    // Registered read; holds between reads so data_out is stable across the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
        end else if (rd_en) begin
            data_out_q <= mem[addr];
        end
    end

    // Storage is never cleared; reset only suppresses a write in its own cycle.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[we_addr] <= we_data;
        end
    end

    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign load_done  = load_done_q;
    assign busy       = (state_q == LOAD);
    assign load_ready = (state_q == LOAD);

endmodule

// File: tb/tb_bus_ram.sv
// Testbench for bus_ram: randomized CPU accesses and load sessions against a
// plain array model of the memory. Expected read data and load_done events are
// queued when stimulus is issued; a monitor pops and compares them whenever
// the DUT drives data_oe or load_done.
module tb_bus_ram;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_clk;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              busy;

    always #5 clk = ~clk;

    bus_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_clk   (mem_clk),
        .addr      (addr),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .load_done (load_done),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] rd_q [$];
    int                done_q [$];
    logic [DATA_W-1:0] bq [$];
    bit                mon_en = 1'b0;
    int                run_len = 0;
    logic [DATA_W-1:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=asserted required=quiet t=%0t", name, $time);
    endtask

    // Monitor: each read gives exactly two data_oe cycles, so within a run of
    // high cycles every even position starts a new response.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_oe === 1'b1) begin
                if (run_len % 2 == 0) begin
                    if (rd_q.size() == 0) begin
                        unexpected("unexpected_data_oe");
                    end else begin
                        chk("read_data", 32'(data_out), 32'(rd_q.pop_front()));
                    end
                    held = data_out;
                end else begin
                    chk("read_hold", 32'(data_out), 32'(held));
                end
                run_len++;
            end else begin
                if (run_len != 0) begin
                    chk("oe_window_len", run_len % 2, 0);
                end
                run_len = 0;
            end

            if (load_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    unexpected("unexpected_load_done");
                end else begin
                    void'(done_q.pop_front());
                    chk("busy_at_done", 32'(busy), 0);
                    chk("ready_at_done", 32'(load_ready), 0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_clk    = 1'b0;
        wr_en      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // A stray load beat rides along to confirm beats are ignored outside LOAD.
    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_clk    = 1'b1;
        wr_en      = 1'b1;
        addr       = a;
        data_in    = d;
        load_valid = 1'b1;
        load_data  = 8'($urandom);
        model[a]   = d;
        $display("write addr=%02h data=%02h", a, d);
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, input int hold_cycles);
        mem_clk = 1'b1;
        wr_en   = 1'b0;
        addr    = a;
        rd_q.push_back(model[a]);
        $display("read  addr=%02h expect=%02h strobe_high=%0d", a, model[a], hold_cycles);
        repeat (hold_cycles) cyc();
        idle_inputs();
        repeat (3) cyc();
    endtask

    // Second read lands on the final cycle of the first window.
    task automatic read_restart(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        mem_clk = 1'b1;
        wr_en   = 1'b0;
        addr    = a1;
        rd_q.push_back(model[a1]);
        cyc();
        mem_clk = 1'b0;
        cyc();
        mem_clk = 1'b1;
        addr    = a2;
        rd_q.push_back(model[a2]);
        $display("read2 addr=%02h expect=%02h then addr=%02h expect=%02h",
                 a1, model[a1], a2, model[a2]);
        cyc();
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic load_session(input logic [DATA_W-1:0] beats [$], input bit use_last,
                                input bit noise, input bit coinc,
                                input logic [ADDR_W-1:0] ca, input bit abort);
        int ptr;
        int n;
        bit ended;
        ptr   = 0;
        ended = 1'b0;
        n     = beats.size();
        load_start = 1'b1;
        if (coinc) begin
            mem_clk = 1'b1;
            wr_en   = 1'b1;
            addr    = ca;
            data_in = 8'($urandom);
        end
        cyc();
        idle_inputs();
        chk("busy_in_load", 32'(busy), 1);
        chk("ready_in_load", 32'(load_ready), 1);
        for (int i = 0; i < n && !ended; i++) begin
            if (noise) begin
                while ($urandom_range(0, 2) == 0) begin
                    mem_clk    = 1'b1;
                    wr_en      = 1'b1;
                    addr       = 8'($urandom);
                    data_in    = 8'($urandom);
                    load_start = 1'($urandom_range(0, 1));
                    cyc();
                    idle_inputs();
                end
            end
            load_valid = 1'b1;
            load_data  = beats[i];
            load_last  = use_last && (i == n - 1);
            model[ptr] = beats[i];
            if (load_last || ptr == DEPTH - 1) begin
                ended = 1'b1;
                done_q.push_back(1);
            end
            ptr++;
            cyc();
            idle_inputs();
        end
        if (abort) begin
            reset = 1'b1;
            cyc();
            reset = 1'b0;
        end
        if (ended || abort) begin
            chk("busy_after_session", 32'(busy), 0);
            chk("ready_after_session", 32'(load_ready), 0);
            chk("oe_after_session", 32'(data_oe), 0);
        end
        $display("load  beats=%0d written=%0d last=%0d noise=%0d coinc=%0d abort=%0d",
                 n, ptr, use_last, noise, coinc, abort);
        cyc();
    endtask

    initial begin
        idle_inputs();
        addr      = '0;
        data_in   = '0;
        load_data = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", 32'(data_out), 0);
        chk("reset_data_oe", 32'(data_oe), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_load_ready", 32'(load_ready), 0);
        chk("reset_load_done", 32'(load_done), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        cyc();

        // Full-depth load without load_last: ends on wrap, fills every word.
        bq.delete();
        repeat (DEPTH) bq.push_back(8'($urandom));
        load_session(bq, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cpu_read(8'hFF, 1);
        cpu_read(8'h00, 1);

        // Three-beat session: pointer restarts at 0 after the wrap.
        bq = '{8'hA1, 8'hB2, 8'hC3};
        load_session(bq, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cpu_read(8'h00, 1);
        cpu_read(8'h01, 1);
        cpu_read(8'h02, 1);

        cpu_write(8'h10, 8'h5A);
        cpu_read(8'h10, 1);
        read_restart(8'h10, 8'h02);
        cpu_read(8'h01, 3);

        // load_start together with a write strobe: the write is dropped.
        bq.delete();
        repeat (3) bq.push_back(8'($urandom));
        load_session(bq, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        cpu_read(8'h80, 1);

        // Session with gaps, ignored strobes and ignored load_start pulses.
        bq.delete();
        repeat (12) bq.push_back(8'($urandom));
        load_session(bq, 1'b1, 1'b1, 1'b0, '0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: cpu_write(8'($urandom), 8'($urandom));
                1: cpu_read(8'($urandom), 1);
                2: read_restart(8'($urandom), 8'($urandom));
                default: cpu_read(8'($urandom), int'($urandom_range(2, 3)));
            endcase
        end

        // Reset after two beats: no load_done, beats kept.
        bq.delete();
        repeat (2) bq.push_back(8'($urandom));
        load_session(bq, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        cpu_read(8'h01, 1);
        cpu_read(8'h00, 1);

        for (int a = 0; a < DEPTH; a++) begin
            cpu_read(8'(a), 1);
        end

        repeat (4) cyc();
        chk("reads_outstanding", rd_q.size(), 0);
        chk("load_done_outstanding", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
